// File: rtl/xregf_host_port_pkg.sv
// xregf_host_port_pkg
//
// Shared definitions for the xregf host port arbiter: regf data/address
// widths, the host-port FSM state encoding and a helper that sizes the
// host wait counter.
package xregf_host_port_pkg;

    localparam int DATA_W      = 32;
    localparam int REGF_ADDR_W = 4;

    // Host-port FSM states. The encodings are fixed because other tooling
    // in the xregf slice decodes them as plain 2-bit values.
    typedef enum logic [1:0] {
        HP_IDLE = 2'd0,
        HP_PEND = 2'd1,
        HP_DONE = 2'd2
    } hp_state_t;

    // Width of a counter that must hold 0..max_wait. It is never narrower
    // than one bit, so MAX_WAIT=0 still yields a legal vector.
    function automatic int wait_cnt_width(input int max_wait);
        if (max_wait < 1) begin
            return 1;
        end
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/xregf_host_port.sv
// xregf_host_port
//
// Arbiter in front of the single xregf access port. The CPU has priority
// and its path to the regf is purely combinational. A host/debug port
// (level req, one-cycle ack) slips its access into a CPU-idle cycle. If the
// CPU keeps the port busy for MAX_WAIT cycles, the host is forced in and
// the CPU is stalled for that one cycle.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   cpu_sel/we/addr/data_in   CPU request into the regf
//   cpu_data_out     regf read data to the CPU (0 while the host owns the port)
//   cpu_stall        CPU access was not performed; CPU must repeat it
//   host_req/we/addr/wdata    host request, sampled while the FSM is idle
//   host_ack         one-cycle pulse when the host access has completed
//   host_rdata       registered host read data, held until the next host read
//   rf_sel/we/addr/data_in    drive the xregf port
//   rf_data_out      combinational read data from xregf
module xregf_host_port
    import xregf_host_port_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   cpu_sel,
    input  logic                   cpu_we,
    input  logic [REGF_ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0]      cpu_data_in,
    output logic [DATA_W-1:0]      cpu_data_out,
    output logic                   cpu_stall,

    input  logic                   host_req,
    input  logic                   host_we,
    input  logic [REGF_ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0]      host_wdata,
    output logic                   host_ack,
    output logic [DATA_W-1:0]      host_rdata,

    output logic                   rf_sel,
    output logic                   rf_we,
    output logic [REGF_ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0]      rf_data_in,
    input  logic [DATA_W-1:0]      rf_data_out
);

    localparam int              CNT_W      = wait_cnt_width(MAX_WAIT);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    hp_state_t              state;
    hp_state_t              state_next;
    logic [CNT_W-1:0]       wait_cnt;
    logic                   pend_we;
    logic [REGF_ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0]      pend_wdata;
    logic                   host_grant;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HP_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and host grant decision. The grant is masked while
    // reset is asserted so the regf port keeps following the CPU even if
    // reset lands on a PEND cycle.
    always_comb begin
        state_next = state;
        host_grant = 1'b0;
        case (state)
            HP_IDLE: begin
                if (host_req) begin
                    state_next = HP_PEND;
                end
            end
            HP_PEND: begin
                if (!cpu_sel || (wait_cnt == WAIT_LIMIT)) begin
                    host_grant = !rst;
                    state_next = HP_DONE;
                end
            end
            HP_DONE: begin
                state_next = HP_IDLE;
            end
            default: begin
                state_next = HP_IDLE;
            end
        endcase
    end

    // Pending request capture, wait counter and host read-data register.
    // The counter saturates at the limit, where the grant fires anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt   <= '0;
            pend_we    <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
            host_rdata <= '0;
        end else begin
            if (state == HP_IDLE && host_req) begin
                pend_we    <= host_we;
                pend_addr  <= host_addr;
                pend_wdata <= host_wdata;
                wait_cnt   <= '0;
            end else if (state == HP_PEND && !host_grant && wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (host_grant && !pend_we) begin
                host_rdata <= rf_data_out;
            end
        end
    end

    // Port mux: the CPU drives the regf unless the host holds the grant,
    // in which case the CPU sees a stall (if it was asking) and zero data,
    // and its write never reaches the regf.
    always_comb begin
        rf_sel       = cpu_sel;
        rf_we        = cpu_we;
        rf_addr      = cpu_addr;
        rf_data_in   = cpu_data_in;
        cpu_data_out = rf_data_out;
        cpu_stall    = 1'b0;
        if (host_grant) begin
            rf_sel       = 1'b1;
            rf_we        = pend_we;
            rf_addr      = pend_addr;
            rf_data_in   = pend_wdata;
            cpu_data_out = '0;
            cpu_stall    = cpu_sel;
        end
    end

    assign host_ack = (state == HP_DONE) && !rst;

endmodule

// File: tb/tb_xregf_host_port.sv
// tb_xregf_host_port
//
// Bench for xregf_host_port with a small behavioural regf attached
// (combinational read, write at posedge). Inputs change 1 time unit after
// the rising edge; outputs are compared at the falling edge.
module tb_xregf_host_port;
    import xregf_host_port_pkg::*;

    logic                   clk;
    logic                   rst;
    logic                   cpu_sel;
    logic                   cpu_we;
    logic [REGF_ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0]      cpu_data_in;
    logic [DATA_W-1:0]      cpu_data_out;
    logic                   cpu_stall;
    logic                   host_req;
    logic                   host_we;
    logic [REGF_ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0]      host_wdata;
    logic                   host_ack;
    logic [DATA_W-1:0]      host_rdata;
    logic                   rf_sel;
    logic                   rf_we;
    logic [REGF_ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0]      rf_data_in;
    logic [DATA_W-1:0]      rf_data_out;

    logic [DATA_W-1:0] regf_mem [16];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        cpu_sel;
        logic        cpu_we;
        logic [3:0]  cpu_addr;
        logic [31:0] cpu_wdata;
        logic        host_req;
        logic        host_we;
        logic [3:0]  host_addr;
        logic [31:0] host_wdata;
        logic        exp_stall;
        logic        exp_ack;
        logic        exp_rf_sel;
        logic        exp_rf_we;
        logic [3:0]  exp_rf_addr;
        logic [31:0] exp_cpu_dout;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [15];

    xregf_host_port #(.MAX_WAIT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_sel      (cpu_sel),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .cpu_stall    (cpu_stall),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata),
        .rf_sel       (rf_sel),
        .rf_we        (rf_we),
        .rf_addr      (rf_addr),
        .rf_data_in   (rf_data_in),
        .rf_data_out  (rf_data_out)
    );

    // Behavioural regf standing in for xregf.
    assign rf_data_out = regf_mem[rf_addr];

    always @(posedge clk) begin
        if (rf_sel && rf_we) begin
            regf_mem[rf_addr] <= rf_data_in;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic c_sel, input logic c_we, input logic [3:0] c_addr,
                                 input logic [31:0] c_wdata, input logic h_req, input logic h_we,
                                 input logic [3:0] h_addr, input logic [31:0] h_wdata);
        cpu_sel     = c_sel;
        cpu_we      = c_we;
        cpu_addr    = c_addr;
        cpu_data_in = c_wdata;
        host_req    = h_req;
        host_we     = h_we;
        host_addr   = h_addr;
        host_wdata  = h_wdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        int  wait_n;
        bit  got_ack;

        // Reset held for two cycles with a host request already raised.
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'd2, 32'h0, 1'b1, 1'b1, 4'd3, 32'h1234);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkOutput("rst_ack", {31'b0, host_ack}, 32'd0);
            checkOutput("rst_stall", {31'b0, cpu_stall}, 32'd0);
            checkOutput("rst_rdata", host_rdata, 32'd0);
            checkOutput("rst_rf_sel", {31'b0, rf_sel}, 32'd1);
            checkOutput("rst_rf_addr", {28'b0, rf_addr}, 32'd2);
            tick();
        end
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'd2, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("post_rst_ack", {31'b0, host_ack}, 32'd0);
            checkOutput("post_rst_stall", {31'b0, cpu_stall}, 32'd0);
            tick();
        end

        // Preload the regf through the CPU path: regf[i] = 0xA0 + i.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 4'(i), 32'hA0 + 32'(i), 1'b0, 1'b0, 4'd0, 32'h0);
            tick();
        end

        // Idle host write/read, CPU path, host-write-then-CPU-read ordering,
        // CPU-write-then-host-read ordering.
        vecs[0]  = '{1'b0,1'b0,4'd0,32'h0,  1'b1,1'b1,4'd3,32'hDEADBEEF, 1'b0,1'b0,1'b0,1'b0,4'd0, 32'hA0,       1'b1,32'h0};
        vecs[1]  = '{1'b0,1'b0,4'd0,32'h0,  1'b1,1'b1,4'd3,32'hDEADBEEF, 1'b0,1'b0,1'b1,1'b1,4'd3, 32'h0,        1'b0,32'h0};
        vecs[2]  = '{1'b1,1'b0,4'd3,32'h0,  1'b1,1'b1,4'd3,32'hDEADBEEF, 1'b0,1'b1,1'b1,1'b0,4'd3, 32'hDEADBEEF, 1'b1,32'h0};
        vecs[3]  = '{1'b0,1'b0,4'd4,32'h0,  1'b1,1'b0,4'd3,32'h0,        1'b0,1'b0,1'b0,1'b0,4'd4, 32'hA4,       1'b0,32'h0};
        vecs[4]  = '{1'b0,1'b0,4'd4,32'h0,  1'b1,1'b0,4'd3,32'h0,        1'b0,1'b0,1'b1,1'b0,4'd3, 32'h0,        1'b0,32'h0};
        vecs[5]  = '{1'b0,1'b0,4'd4,32'h0,  1'b1,1'b0,4'd3,32'h0,        1'b0,1'b1,1'b0,1'b0,4'd4, 32'hA4,       1'b1,32'hDEADBEEF};
        vecs[6]  = '{1'b1,1'b1,4'd6,32'h55, 1'b0,1'b0,4'd0,32'h0,        1'b0,1'b0,1'b1,1'b1,4'd6, 32'hA6,       1'b1,32'hDEADBEEF};
        vecs[7]  = '{1'b1,1'b0,4'd6,32'h0,  1'b0,1'b0,4'd0,32'h0,        1'b0,1'b0,1'b1,1'b0,4'd6, 32'h55,       1'b0,32'h0};
        vecs[8]  = '{1'b0,1'b0,4'd0,32'h0,  1'b1,1'b1,4'd1,32'h9,        1'b0,1'b0,1'b0,1'b0,4'd0, 32'hA0,       1'b0,32'h0};
        vecs[9]  = '{1'b0,1'b0,4'd0,32'h0,  1'b1,1'b1,4'd1,32'h9,        1'b0,1'b0,1'b1,1'b1,4'd1, 32'h0,        1'b0,32'h0};
        vecs[10] = '{1'b1,1'b0,4'd1,32'h0,  1'b1,1'b1,4'd1,32'h9,        1'b0,1'b1,1'b1,1'b0,4'd1, 32'h9,        1'b1,32'hDEADBEEF};
        vecs[11] = '{1'b1,1'b1,4'd7,32'h77, 1'b1,1'b0,4'd7,32'h0,        1'b0,1'b0,1'b1,1'b1,4'd7, 32'hA7,       1'b0,32'h0};
        vecs[12] = '{1'b0,1'b0,4'd7,32'h0,  1'b1,1'b0,4'd7,32'h0,        1'b0,1'b0,1'b1,1'b0,4'd7, 32'h0,        1'b0,32'h0};
        vecs[13] = '{1'b0,1'b0,4'd0,32'h0,  1'b1,1'b0,4'd7,32'h0,        1'b0,1'b1,1'b0,1'b0,4'd0, 32'hA0,       1'b1,32'h77};
        vecs[14] = '{1'b0,1'b0,4'd0,32'h0,  1'b0,1'b0,4'd0,32'h0,        1'b0,1'b0,1'b0,1'b0,4'd0, 32'hA0,       1'b1,32'h77};

        for (int v = 0; v < 15; v++) begin
            applyStimulus(vecs[v].cpu_sel, vecs[v].cpu_we, vecs[v].cpu_addr, vecs[v].cpu_wdata,
                          vecs[v].host_req, vecs[v].host_we, vecs[v].host_addr, vecs[v].host_wdata);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_stall", v), {31'b0, cpu_stall}, {31'b0, vecs[v].exp_stall});
            checkOutput($sformatf("vec%0d_ack", v), {31'b0, host_ack}, {31'b0, vecs[v].exp_ack});
            checkOutput($sformatf("vec%0d_rf_sel", v), {31'b0, rf_sel}, {31'b0, vecs[v].exp_rf_sel});
            checkOutput($sformatf("vec%0d_rf_we", v), {31'b0, rf_we}, {31'b0, vecs[v].exp_rf_we});
            checkOutput($sformatf("vec%0d_rf_addr", v), {28'b0, rf_addr}, {28'b0, vecs[v].exp_rf_addr});
            checkOutput($sformatf("vec%0d_cpu_dout", v), cpu_data_out, vecs[v].exp_cpu_dout);
            if (vecs[v].chk_rdata) begin
                checkOutput($sformatf("vec%0d_rdata", v), host_rdata, vecs[v].exp_rdata);
            end
            tick();
        end

        // Contention: CPU busy every cycle, host read of addr 5 forced in on
        // the 16th PEND cycle. The CPU write to addr 2 in that cycle must be
        // dropped and then land on the retry.
        applyStimulus(1'b1, 1'b0, 4'd9, 32'h0, 1'b1, 1'b0, 4'd5, 32'h0);
        @(negedge clk);
        checkOutput("cont_idle_stall", {31'b0, cpu_stall}, 32'd0);
        tick();
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) begin
                applyStimulus(1'b1, 1'b1, 4'd2, 32'h7, 1'b1, 1'b0, 4'd5, 32'h0);
            end
            @(negedge clk);
            checkOutput($sformatf("cont_pend%0d_stall", i), {31'b0, cpu_stall}, (i == 16) ? 32'd1 : 32'd0);
            checkOutput($sformatf("cont_pend%0d_ack", i), {31'b0, host_ack}, 32'd0);
            if (i == 16) begin
                checkOutput("cont_grant_rf_addr", {28'b0, rf_addr}, 32'd5);
                checkOutput("cont_grant_rf_we", {31'b0, rf_we}, 32'd0);
                checkOutput("cont_grant_cpu_dout", cpu_data_out, 32'd0);
            end else begin
                checkOutput($sformatf("cont_pend%0d_cpu_dout", i), cpu_data_out, 32'hA9);
            end
            tick();
        end
        applyStimulus(1'b1, 1'b1, 4'd2, 32'h7, 1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        checkOutput("cont_done_ack", {31'b0, host_ack}, 32'd1);
        checkOutput("cont_done_stall", {31'b0, cpu_stall}, 32'd0);
        checkOutput("cont_done_rdata", host_rdata, 32'hA5);
        checkOutput("cont_regf2_unchanged", cpu_data_out, 32'hA2);
        tick();
        applyStimulus(1'b1, 1'b0, 4'd2, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        checkOutput("cont_retry_regf2", cpu_data_out, 32'h7);
        checkOutput("cont_after_ack", {31'b0, host_ack}, 32'd0);
        tick();

        // Reset while the host write to addr 4 is stuck in PEND.
        applyStimulus(1'b1, 1'b0, 4'd9, 32'h0, 1'b1, 1'b1, 4'd4, 32'hBAD);
        for (int c = 0; c < 4; c++) begin
            tick();
        end
        rst = 1'b1;
        host_req = 1'b0;
        @(negedge clk);
        checkOutput("midrst_ack", {31'b0, host_ack}, 32'd0);
        checkOutput("midrst_stall", {31'b0, cpu_stall}, 32'd0);
        checkOutput("midrst_rf_addr", {28'b0, rf_addr}, 32'd9);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("midrst_after_ack", {31'b0, host_ack}, 32'd0);
            tick();
        end
        checkOutput("midrst_rdata_cleared", host_rdata, 32'd0);
        applyStimulus(1'b1, 1'b0, 4'd4, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        checkOutput("midrst_regf4_unchanged", cpu_data_out, 32'hA4);
        tick();

        // A fresh request after the aborted one completes with normal latency.
        applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 4'd4, 32'h44);
        got_ack = 1'b0;
        wait_n  = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (host_ack) begin
                got_ack = 1'b1;
                wait_n  = k;
                break;
            end
            tick();
        end
        if (!got_ack) begin
            checks++;
            errors++;
            $display("[TB] FAIL retry_ack_timeout: no ack within 20 cycles, expected ack after 2");
        end else begin
            checkOutput("retry_ack_latency", 32'(wait_n), 32'd2);
        end
        tick();
        applyStimulus(1'b1, 1'b0, 4'd4, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        checkOutput("retry_regf4", cpu_data_out, 32'h44);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
